instruction_fetch_memory: RTL and testbench
===========================================

Name: instruction_fetch_memory

Overview:
- Program memory and instruction register in one block for the CPU fetch path.
- Synchronous write port loads the program; `program_counter` addresses the memory.
- `instruction` presents the word stored at `program_counter`.
- Sits between the program counter logic and the decoder.

Parameters:
- MEMORY_CELL_COUNT, 256, number of memory words.
- MEMORY_LINE_WIDTH, 16, bits per word and instruction width.
- MEMORY_ADDRESS_WIDTH, 8, width of write address and program counter; must satisfy 2^MEMORY_ADDRESS_WIDTH >= MEMORY_CELL_COUNT.

Ports:
- clock  input  1  single system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- write_enable  input  1  when high, store write_data at write_address on rising clock edge.
- write_address  input  MEMORY_ADDRESS_WIDTH  target word of a write.
- write_data  input  MEMORY_LINE_WIDTH  data to store.
- program_counter  input  MEMORY_ADDRESS_WIDTH  fetch address.
- instruction  output  MEMORY_LINE_WIDTH  word at program_counter.

Behaviour:
- Storage: MEMORY_CELL_COUNT words of MEMORY_LINE_WIDTH bits. Internal read address is program_counter, passed straight through with no offset or scaling.
- Reset:
  - On a rising edge with reset=1, every memory word becomes 0.
  - reset has priority over write_enable; a write in the same cycle is discarded.
  - After that edge, instruction=0 for every program_counter value.
- Write:
  - On a rising edge with reset=0 and write_enable=1, mem[write_address] <= write_data.
  - With write_enable=0, memory holds its contents.
- Read/fetch:
  - Combinational (zero-cycle latency): instruction = mem[program_counter].
  - Changes within the same cycle program_counter changes.
  - No clock edge is needed to update instruction.
- Read-during-write, same address: before the edge instruction shows the old word; after the edge it shows the new word. No write-through bypass.
- Out-of-range addresses (>= MEMORY_CELL_COUNT, only possible when the count is not a power of two):
  - Writes are ignored.
  - Fetch returns 0.
- Widths: write_data stored verbatim, no truncation or sign handling. Address arithmetic is unsigned.
- Initial state before the first reset is undefined (X allowed). Verification must apply reset first.
- No handshake or busy flag; a write is accepted every cycle.

Test Plan:
- Reset: hold reset=1 for one rising edge with write_enable=1, write_address=5, write_data=16'hFFFF, then reset=0. Sweep program_counter 0..255 → instruction=0 everywhere, including address 5.
- Full load and readback:
  - Load: for i=0..255, write_enable=1, write_address=i, write_data=3*i+1, one edge each.
  - Readback: write_enable=0, sweep program_counter 0..255 → instruction=3*pc+1. Examples: pc=0→1, pc=1→4, pc=85→256, pc=255→766 (16'b0000001011111110).
- Combinational fetch: after the load, change program_counter from 10 to 20 mid-cycle with no clock edge → instruction goes 31→61 immediately.
- Write enable gating: write_enable=0, write_address=7, write_data=16'hABCD, several edges → pc=7 still reads 22.
- Read-during-write: program_counter=3 (holds 10); write 16'h1234 to address 3 → instruction=10 before the edge, 16'h1234 after.
- Mid-operation reset: after the load, assert reset for one edge during an active write stream → all addresses read 0 afterwards; subsequent writes with reset=0 store normally.

Source files
------------

// File: rtl/instruction_fetch_memory_if.sv
// Fetch-path bus between the program loader / PC logic and the program memory.
interface instruction_fetch_memory_if #(
  parameter int unsigned MEMORY_LINE_WIDTH    = 16,
  parameter int unsigned MEMORY_ADDRESS_WIDTH = 8
);

  logic                            write_enable;
  logic [MEMORY_ADDRESS_WIDTH-1:0] write_address;
  logic [MEMORY_LINE_WIDTH-1:0]    write_data;
  logic [MEMORY_ADDRESS_WIDTH-1:0] program_counter;
  logic [MEMORY_LINE_WIDTH-1:0]    instruction;

  // Loader / PC side: drives writes and the fetch address, receives the instruction.
  modport master (
    output write_enable,
    output write_address,
    output write_data,
    output program_counter,
    input  instruction
  );

  // Memory side.
  modport slave (
    input  write_enable,
    input  write_address,
    input  write_data,
    input  program_counter,
    output instruction
  );

endinterface

// File: rtl/instruction_fetch_memory.sv
// Program memory with a synchronous write port and a zero-latency fetch port.
// The fetch output is a direct combinational read of the word at program_counter.
module instruction_fetch_memory #(
  parameter int unsigned MEMORY_CELL_COUNT    = 256,
  parameter int unsigned MEMORY_LINE_WIDTH    = 16,
  parameter int unsigned MEMORY_ADDRESS_WIDTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  instruction_fetch_memory_if.slave   bus
);

  localparam int unsigned ADDRESS_SPACE = 2 ** MEMORY_ADDRESS_WIDTH;

  logic [MEMORY_LINE_WIDTH-1:0] mem [MEMORY_CELL_COUNT];
  logic                         write_in_range_c;
  logic                         read_in_range_c;

  // Range checks only exist when the address space is larger than the memory.
  if (ADDRESS_SPACE > MEMORY_CELL_COUNT) begin : g_partial_space
    assign write_in_range_c = (32'(bus.write_address)   < MEMORY_CELL_COUNT);
    assign read_in_range_c  = (32'(bus.program_counter) < MEMORY_CELL_COUNT);
  end else begin : g_full_space
    assign write_in_range_c = 1'b1;
    assign read_in_range_c  = 1'b1;
  end

  // Storage update: reset clears every word and overrides a concurrent write.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (bus.write_enable && write_in_range_c) begin
      mem[bus.write_address] <= bus.write_data;
    end
  end

  // Fetch: no bypass, so a same-address write becomes visible after the edge.
  assign bus.instruction = read_in_range_c ? mem[bus.program_counter]
                                           : '0;

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Directed self-checking bench for instruction_fetch_memory.
module tb_instruction_fetch_memory;

  localparam int unsigned CELLS = 256;
  localparam int unsigned LW    = 16;
  localparam int unsigned AW    = 8;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  instruction_fetch_memory_if #(
    .MEMORY_LINE_WIDTH    (LW),
    .MEMORY_ADDRESS_WIDTH (AW)
  ) bus ();

  instruction_fetch_memory #(
    .MEMORY_CELL_COUNT    (CELLS),
    .MEMORY_LINE_WIDTH    (LW),
    .MEMORY_ADDRESS_WIDTH (AW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reset with a colliding write, then every address must read zero.
  task automatic test_reset();
    reset             = 1'b1;
    bus.write_enable  = 1'b1;
    bus.write_address = 8'd5;
    bus.write_data    = 16'hFFFF;
    @(posedge clock); #1;
    reset            = 1'b0;
    bus.write_enable = 1'b0;
    for (int pc = 0; pc < 256; pc++) begin
      bus.program_counter = 8'(pc);
      #1;
      total++;
      if (bus.instruction !== 16'h0000) begin
        bad++;
        $display("FAIL reset_clear pc=%0d got=%h exp=0000", pc, bus.instruction);
      end
    end
  endtask

  // Load 3*i+1 everywhere and read all of it back.
  task automatic test_load_readback();
    logic [LW-1:0] exp;
    for (int i = 0; i < 256; i++) begin
      bus.write_enable  = 1'b1;
      bus.write_address = 8'(i);
      bus.write_data    = 16'(3 * i + 1);
      @(posedge clock); #1;
    end
    bus.write_enable = 1'b0;
    for (int pc = 0; pc < 256; pc++) begin
      bus.program_counter = 8'(pc);
      exp = 16'(3 * pc + 1);
      #1;
      total++;
      if (bus.instruction !== exp) begin
        bad++;
        $display("FAIL readback pc=%0d got=%h exp=%h", pc, bus.instruction, exp);
      end
    end
    // Hand-computed spot values.
    bus.program_counter = 8'd85;
    #1;
    total++;
    if (bus.instruction !== 16'd256) begin
      bad++;
      $display("FAIL readback_85 got=%h exp=%h", bus.instruction, 16'd256);
    end
    bus.program_counter = 8'd255;
    #1;
    total++;
    if (bus.instruction !== 16'b0000001011111110) begin
      bad++;
      $display("FAIL readback_255 got=%h exp=%h", bus.instruction, 16'd766);
    end
  endtask

  // Fetch follows program_counter without waiting for a clock edge.
  task automatic test_comb_fetch();
    @(posedge clock); #1;
    bus.program_counter = 8'd10;
    #1;
    total++;
    if (bus.instruction !== 16'd31) begin
      bad++;
      $display("FAIL comb_fetch_10 got=%0d exp=31", bus.instruction);
    end
    bus.program_counter = 8'd20;
    #1;
    total++;
    if (bus.instruction !== 16'd61) begin
      bad++;
      $display("FAIL comb_fetch_20 got=%0d exp=61", bus.instruction);
    end
  endtask

  // With write_enable low nothing is stored.
  task automatic test_write_enable_gating();
    bus.write_enable  = 1'b0;
    bus.write_address = 8'd7;
    bus.write_data    = 16'hABCD;
    repeat (3) @(posedge clock);
    #1;
    bus.program_counter = 8'd7;
    #1;
    total++;
    if (bus.instruction !== 16'd22) begin
      bad++;
      $display("FAIL we_gating got=%h exp=%h", bus.instruction, 16'd22);
    end
  endtask

  // Same-address write: old word before the edge, new word after.
  task automatic test_read_during_write();
    @(posedge clock); #1;
    bus.program_counter = 8'd3;
    bus.write_enable    = 1'b1;
    bus.write_address   = 8'd3;
    bus.write_data      = 16'h1234;
    #1;
    total++;
    if (bus.instruction !== 16'd10) begin
      bad++;
      $display("FAIL rdw_before got=%h exp=%h", bus.instruction, 16'd10);
    end
    @(posedge clock); #1;
    bus.write_enable = 1'b0;
    total++;
    if (bus.instruction !== 16'h1234) begin
      bad++;
      $display("FAIL rdw_after got=%h exp=1234", bus.instruction);
    end
  endtask

  // Reset during a write stream clears everything; later writes work.
  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin
      bus.write_enable  = 1'b1;
      bus.write_address = 8'(100 + i);
      bus.write_data    = 16'(16'h5A00 + i);
      @(posedge clock); #1;
    end
    reset             = 1'b1;
    bus.write_address = 8'd104;
    bus.write_data    = 16'h5A04;
    @(posedge clock); #1;
    reset            = 1'b0;
    bus.write_enable = 1'b0;
    for (int pc = 0; pc < 256; pc++) begin
      bus.program_counter = 8'(pc);
      #1;
      total++;
      if (bus.instruction !== 16'h0000) begin
        bad++;
        $display("FAIL mid_reset_clear pc=%0d got=%h exp=0000", pc, bus.instruction);
      end
    end
    bus.write_enable  = 1'b1;
    bus.write_address = 8'd50;
    bus.write_data    = 16'hBEEF;
    @(posedge clock); #1;
    bus.write_address = 8'd51;
    bus.write_data    = 16'h0042;
    @(posedge clock); #1;
    bus.write_enable = 1'b0;
    bus.program_counter = 8'd50;
    #1;
    total++;
    if (bus.instruction !== 16'hBEEF) begin
      bad++;
      $display("FAIL post_reset_write_50 got=%h exp=beef", bus.instruction);
    end
    bus.program_counter = 8'd51;
    #1;
    total++;
    if (bus.instruction !== 16'h0042) begin
      bad++;
      $display("FAIL post_reset_write_51 got=%h exp=0042", bus.instruction);
    end
    bus.program_counter = 8'd52;
    #1;
    total++;
    if (bus.instruction !== 16'h0000) begin
      bad++;
      $display("FAIL post_reset_untouched_52 got=%h exp=0000", bus.instruction);
    end
  endtask

  initial begin
    total               = 0;
    bad                 = 0;
    reset               = 1'b0;
    bus.write_enable    = 1'b0;
    bus.write_address   = '0;
    bus.write_data      = '0;
    bus.program_counter = '0;
    @(negedge clock);
    test_reset();
    test_load_readback();
    test_comb_fetch();
    test_write_enable_gating();
    test_read_during_write();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
